// File: rtl/rng_lane_arbiter.sv
// rng_lane_arbiter: runs a shared xorshift256 generator through seed/warm-up/fill and deals each
// 256-bit draw as four 64-bit words to round-robin requesters, one word per cycle.
module rng_lane_arbiter #(
   parameter int           NUM_REQ      = 4,
   parameter int           WARMUP       = 16,
   parameter logic [255:0] DEFAULT_SEED = 256'h9E3779B97F4A7C15_F39CC0605CEDC834_1082276BF3A27251_F86C6A11D0C18E95
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [255:0]       seed_in,
   input  logic               seed_valid,
   output logic               seed_ready,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [63:0]        rand_data,
   output logic               busy,
   output logic               gen_rst,
   output logic               gen_en,
   output logic [255:0]       gen_seed,
   input  logic [255:0]       gen_rand
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;
   typedef enum logic [1:0] {SEED, WARM, FILL, SERVE} state_t;
   state_t        state, state_nxt;
   logic [255:0]  seed_reg, buffer;
   logic [1:0]    lane;
   logic [PW-1:0] rr_ptr, winner;
   logic [WW-1:0] warm_cnt;
   logic          found, serve, accept, grant;
   int            idx;
   assign serve      = state == SERVE;
   assign accept     = serve && seed_valid;
   assign grant      = serve && !seed_valid && found;
   assign seed_ready = serve;
   assign busy       = !serve;
   assign gen_rst    = state == SEED;
   assign gen_en     = state == WARM || state == FILL || (grant && lane == 2'd3);
   assign gen_seed   = seed_reg;
   // first asserted request at or above rr_ptr, wrapping
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end
   always_comb begin
      state_nxt = state;
      case (state)
         SEED:    state_nxt = WARMUP == 0 ? FILL : WARM;
         WARM:    state_nxt = warm_cnt == WW'(WARMUP - 1) ? FILL : WARM;
         FILL:    state_nxt = SERVE;
         default: state_nxt = accept ? SEED : SERVE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEED;
         seed_reg  <= DEFAULT_SEED;
         gnt       <= '0;
         rand_data <= '0;
         lane      <= '0;
         rr_ptr    <= '0;
         buffer    <= '0;
         warm_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         warm_cnt <= state == WARM ? warm_cnt + 1'b1 : '0;
         gnt      <= grant ? (NUM_REQ'(1) << winner) : '0;
         if (accept)
            seed_reg <= seed_in;
         if (state == FILL) begin
            buffer <= gen_rand;
            lane   <= '0;
         end else if (grant) begin
            rand_data <= buffer[64*lane +: 64];
            rr_ptr    <= winner == PW'(NUM_REQ - 1) ? '0 : winner + 1'b1;
            lane      <= lane + 1'b1;
            if (lane == 2'd3)
               buffer <= gen_rand;
         end
      end
   end
endmodule

// File: tb/tb_rng_lane_arbiter.sv
// tb_rng_lane_arbiter: drives two arbiters (no warm-up / 16-step warm-up) with emulated generators
// and compares every cycle against a word-stream and round-robin reference model.
module tb_rng_lane_arbiter;
   localparam logic [255:0] DSEED = 256'h9E3779B97F4A7C15_F39CC0605CEDC834_1082276BF3A27251_F86C6A11D0C18E95;
   localparam int WA = 0;
   localparam int WB = 16;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic [255:0] seed_in = '0, gen_seed_a, gen_rand_a, g_a;
   logic         seed_valid = 1'b0, seed_ready_a, busy_a, gen_rst_a, gen_en_a;
   logic [3:0]   req = '0, gnt_a;
   logic [63:0]  rand_data_a;
   logic [3:0]   req_b = 4'b0001, gnt_b;
   logic         seed_ready_b, busy_b, gen_rst_b, gen_en_b;
   logic [63:0]  rand_data_b;
   logic [255:0] gen_seed_b, gen_rand_b, g_b;
   int           checks = 0, failures = 0;
   int           pend, ptr, m_lane;
   logic [255:0] m_draw;
   logic [63:0]  m_last;
   logic [3:0]   e_gnt;
   always #5 clk = ~clk;
   function automatic logic [255:0] xs_next(input logic [255:0] v);
      logic [63:0] s0, s1, s2, s3, t;
      s0 = v[63:0]; s1 = v[127:64]; s2 = v[191:128]; s3 = v[255:192];
      t = s1 << 17;
      s2 ^= s0; s3 ^= s1; s1 ^= s2; s0 ^= s3; s2 ^= t;
      s3 = {s3[18:0], s3[63:19]};
      return {s3, s2, s1, s0};
   endfunction
   always @(posedge clk) g_a <= gen_rst_a ? gen_seed_a : gen_en_a ? xs_next(g_a) : g_a;
   always @(posedge clk) g_b <= gen_rst_b ? gen_seed_b : gen_en_b ? xs_next(g_b) : g_b;
   assign gen_rand_a = xs_next(g_a);
   assign gen_rand_b = xs_next(g_b);
   rng_lane_arbiter #(.NUM_REQ(4), .WARMUP(WA), .DEFAULT_SEED(DSEED)) dut_a (
      .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(seed_ready_a),
      .req(req), .gnt(gnt_a), .rand_data(rand_data_a), .busy(busy_a), .gen_rst(gen_rst_a),
      .gen_en(gen_en_a), .gen_seed(gen_seed_a), .gen_rand(gen_rand_a));
   rng_lane_arbiter #(.NUM_REQ(4), .WARMUP(WB), .DEFAULT_SEED(DSEED)) dut_b (
      .clk(clk), .rst_n(rst_n), .seed_in('0), .seed_valid(1'b0), .seed_ready(seed_ready_b),
      .req(req_b), .gnt(gnt_b), .rand_data(rand_data_b), .busy(busy_b), .gen_rst(gen_rst_b),
      .gen_en(gen_en_b), .gen_seed(gen_seed_b), .gen_rand(gen_rand_b));
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic reseed(input logic [255:0] s);
      pend   = WA + 2;
      m_draw = s;
      repeat (WA + 1) m_draw = xs_next(m_draw);
      m_lane = 0;
   endtask
   task automatic hard_reset;
      ptr    = 0;
      m_last = '0;
      e_gnt  = '0;
      reseed(DSEED);
   endtask
   task automatic take(output logic [63:0] w);
      w = m_draw[64*m_lane +: 64];
      m_lane++;
      if (m_lane == 4) begin
         m_lane = 0;
         m_draw = xs_next(m_draw);
      end
   endtask
   // called at a negedge: drive inputs, check combinational outputs, predict and check the next edge
   task automatic cycle(input logic [3:0] r, input logic sv, input logic [255:0] s);
      logic en_exp;
      int   w;
      req = r; seed_valid = sv; seed_in = s;
      #1;
      check("busy", busy_a, pend != 0);
      check("seed_ready", seed_ready_a, pend == 0);
      check("gen_rst", gen_rst_a, pend == WA + 2);
      en_exp = (pend != 0 && pend != WA + 2) || (pend == 0 && !sv && r != 0 && m_lane == 3);
      check("gen_en", gen_en_a, en_exp);
      e_gnt = '0;
      if (pend != 0) pend--;
      else if (sv) reseed(s);
      else if (r != 0) begin
         w = ptr;
         while (!r[w]) w = (w + 1) % 4;
         e_gnt = 4'b0001 << w;
         take(m_last);
         ptr = (w + 1) % 4;
      end
      @(negedge clk);
      check("gnt", gnt_a, e_gnt);
      check("rand_data", rand_data_a, m_last);
   endtask
   task automatic t6;
      logic [255:0] d;
      int busy_n = 0, en_n = 0, got = 0;
      d = DSEED;
      repeat (WB + 1) d = xs_next(d);
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (busy_b) begin
            busy_n++;
            if (gen_en_b) en_n++;
         end
         if (gnt_b != 0) begin
            check("t6_gnt", gnt_b, 4'b0001);
            check("t6_word", rand_data_b, d[64*(got%4) +: 64]);
            got++;
            if (got == 4) d = xs_next(d);
         end
         @(negedge clk);
      end
      check("t6_busy_cycles", busy_n, WB + 2);
      check("t6_gen_en_cycles", en_n, WB + 1);
      check("t6_words", got, 8);
   endtask
   initial begin
      logic [255:0] s;
      logic         sv_hold, acc;
      @(negedge clk);
      check("rst_gnt", gnt_a, 4'b0);
      check("rst_rand_data", rand_data_a, 64'h0);
      check("rst_busy", busy_a, 1'b1);
      check("rst_gen_rst", gen_rst_a, 1'b1);
      check("rst_seed_ready", seed_ready_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      hard_reset();
      fork
         t6();
         begin
            repeat (10) cycle(4'b0001, 1'b0, '0);
            repeat (12) cycle(4'b1111, 1'b0, '0);
            for (int i = 0; i < 8; i++) cycle(i % 2 == 0 ? 4'b0100 : 4'b0000, 1'b0, '0);
            for (int i = 0; i < 4 && m_lane != 2; i++) cycle(4'b1111, 1'b0, '0);
            check("t4_lane_setup", m_lane, 2);
            cycle(4'b1111, 1'b1, 256'h1);
            repeat (8) cycle(4'b1111, 1'b0, '0);
         end
      join
      sv_hold = 1'b0;
      s = '0;
      for (int i = 0; i < 300; i++) begin
         if (!sv_hold && $urandom_range(0, 30) == 0) begin
            sv_hold = 1'b1;
            s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom | 32'h1};
         end
         acc = sv_hold && pend == 0;
         cycle(4'($urandom), sv_hold, s);
         if (acc) sv_hold = 1'b0;
      end
      repeat (6) cycle(4'b1111, 1'b0, '0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_gnt", gnt_a, 4'b0);
      check("t5_rand_data", rand_data_a, 64'h0);
      check("t5_gen_rst", gen_rst_a, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hard_reset();
      repeat (12) cycle(4'b0001, 1'b0, '0);
      repeat (40) cycle(4'($urandom), 1'b0, '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
